// File: rtl/pc_controller_pkg.sv
// Shared types and constants for the PC controller slice.
// Build macro PC_EXC_EN selects exception-vector handling of misaligned targets.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } pc_state_e;

    localparam logic [31:0] EXC_VECTOR       = 32'h8000_0180;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_controller_if.sv
// Bundle between the PC controller and the fetch/decode/hazard logic.
// Port exc_taken exists only when PC_EXC_EN is defined.
interface pc_controller_if;

    logic [31:0] pc_cur;
    logic        stall_req;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        stall_timeout;
    logic [1:0]  state;
`ifdef PC_EXC_EN
    logic        exc_taken;

    modport master (
        output pc_cur, stall_req, branch_taken, branch_target,
        output jump, jump_target,
        input  pc_next, pc_write, if_id_write, if_id_flush,
        input  stall_timeout, state, exc_taken
    );

    modport slave (
        input  pc_cur, stall_req, branch_taken, branch_target,
        input  jump, jump_target,
        output pc_next, pc_write, if_id_write, if_id_flush,
        output stall_timeout, state, exc_taken
    );
`else
    modport master (
        output pc_cur, stall_req, branch_taken, branch_target,
        output jump, jump_target,
        input  pc_next, pc_write, if_id_write, if_id_flush,
        input  stall_timeout, state
    );

    modport slave (
        input  pc_cur, stall_req, branch_taken, branch_target,
        input  jump, jump_target,
        output pc_next, pc_write, if_id_write, if_id_flush,
        output stall_timeout, state
    );
`endif

endinterface

// File: rtl/pc_controller_stall_watchdog.sv
// Saturating stall-length counter with a sticky overrun flag.
// The flag is cleared only by reset, never by the clear input.
module pc_stall_watchdog #(
    parameter int unsigned STALL_MAX = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic count_en,
    input  logic clear,
    output logic timeout
);

    logic [3:0] cnt_q, cnt_d;
    logic       to_q, to_d;

    always_comb begin
        cnt_d = cnt_q;
        to_d  = to_q;
        if (clear) begin
            cnt_d = 4'd0;
        end else if (count_en && cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (count_en && cnt_d >= 4'(STALL_MAX)) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout = to_q;

endmodule

// File: rtl/pc_controller.sv
// Next-PC selection FSM: reset hold, sequential fetch, stall and redirect flush.
// Define PC_EXC_EN to vector misaligned redirect targets to EXC_VECTOR.
module pc_controller
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned STALL_MAX = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    pc_controller_if.slave   bus
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_seq, tgt, pc_nx;
    logic        redirect, pc_wr, idw, fl;
    logic        count_en, clear, exc;

    assign pc_seq   = bus.pc_cur + INSTR_BYTES;
    assign redirect = bus.jump | bus.branch_taken;
    assign tgt      = bus.jump ? bus.jump_target : bus.branch_target;

    always_comb begin
        state_d  = ST_RUN;
        pc_nx    = pc_seq;
        pc_wr    = 1'b1;
        idw      = 1'b1;
        fl       = 1'b0;
        exc      = 1'b0;
        count_en = 1'b0;
        clear    = 1'b0;
        if (!reset_n) begin
            state_d = ST_HOLD;
            pc_nx   = RESET_PC;
            fl      = 1'b1;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    pc_nx = RESET_PC;
                    fl    = 1'b1;
                end
                ST_RUN, ST_STALL, ST_FLUSH: begin
                    if (bus.stall_req) begin
                        state_d  = ST_STALL;
                        pc_nx    = bus.pc_cur;
                        pc_wr    = 1'b0;
                        idw      = 1'b0;
                        count_en = 1'b1;
                    end else begin
                        clear = 1'b1;
                        // The FLUSH slot holds a squashed instruction.
                        if (redirect && state_q != ST_FLUSH) begin
                            state_d = ST_FLUSH;
                            fl      = 1'b1;
`ifdef PC_EXC_EN
                            if (misaligned(tgt)) begin
                                pc_nx = EXC_VECTOR;
                                exc   = 1'b1;
                            end else begin
                                pc_nx = tgt;
                            end
`else
                            pc_nx = align_word(tgt);
`endif
                        end
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    pc_stall_watchdog #(
        .STALL_MAX (STALL_MAX)
    ) u_wdog (
        .clock    (clock),
        .reset_n  (reset_n),
        .count_en (count_en),
        .clear    (clear),
        .timeout  (bus.stall_timeout)
    );

    assign bus.pc_next     = pc_nx;
    assign bus.pc_write    = pc_wr;
    assign bus.if_id_write = idw;
    assign bus.if_id_flush = fl;
    assign bus.state       = state_q;
`ifdef PC_EXC_EN
    assign bus.exc_taken   = exc;
`endif

endmodule

// File: tb/tb_pc_controller.sv
// Table-driven scoreboard bench for pc_controller.
// Honours PC_EXC_EN for misaligned-target expectations.
module tb_pc_controller;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    pc_controller_if bus();

    pc_controller #(
        .RESET_PC  (32'h0000_0000),
        .STALL_MAX (15)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

`ifdef PC_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam logic [1:0] HOLD  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] STALL = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    localparam logic [31:0] MIS1 = EXC_EN ? 32'h8000_0180 : 32'h100;
    localparam logic [31:0] MIS2 = EXC_EN ? 32'h8000_0180 : 32'h700;

    typedef struct {
        logic        rst_n;
        logic [31:0] pc;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] e_pc;
        logic        e_w;
        logic        e_idw;
        logic        e_fl;
        logic        e_to;
        logic        e_exc;
        logic [1:0]  e_st;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        w;
        logic        idw;
        logic        fl;
        logic        to;
        logic        exc;
        logic [1:0]  st;
        int          tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic r, input logic [31:0] pc,
        input logic s, input logic b, input logic [31:0] bt,
        input logic j, input logic [31:0] jt,
        input logic [31:0] epc, input logic ew, input logic eidw,
        input logic efl, input logic eto, input logic eexc,
        input logic [1:0] est
    );
        vec_t v;
        v.rst_n = r;  v.pc = pc;  v.stall = s;
        v.br = b;  v.bt = bt;  v.jmp = j;  v.jt = jt;
        v.e_pc = epc;  v.e_w = ew;  v.e_idw = eidw;
        v.e_fl = efl;  v.e_to = eto;  v.e_exc = eexc;
        v.e_st = est;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expectation queued");
            return;
        end
        e = sb_q.pop_front();
        if ({bus.pc_next, bus.pc_write, bus.if_id_write, bus.if_id_flush,
             bus.stall_timeout, bus.state} !==
            {e.pc, e.w, e.idw, e.fl, e.to, e.st}) begin
            errors++;
            $display("FAIL step%0d: got pc_next=%h w=%b idw=%b fl=%b to=%b st=%0d, want pc_next=%h w=%b idw=%b fl=%b to=%b st=%0d",
                     e.tag, bus.pc_next, bus.pc_write, bus.if_id_write,
                     bus.if_id_flush, bus.stall_timeout, bus.state,
                     e.pc, e.w, e.idw, e.fl, e.to, e.st);
        end
`ifdef PC_EXC_EN
        checks++;
        if (bus.exc_taken !== e.exc) begin
            errors++;
            $display("FAIL step%0d exc_taken: got %b, want %b",
                     e.tag, bus.exc_taken, e.exc);
        end
`endif
    endtask

    task automatic step(input vec_t v, input int tag);
        exp_t e;
        reset_n           = v.rst_n;
        bus.pc_cur        = v.pc;
        bus.stall_req     = v.stall;
        bus.branch_taken  = v.br;
        bus.branch_target = v.bt;
        bus.jump          = v.jmp;
        bus.jump_target   = v.jt;
        e.pc = v.e_pc;  e.w = v.e_w;  e.idw = v.e_idw;  e.fl = v.e_fl;
        e.to = v.e_to;  e.exc = v.e_exc;  e.st = v.e_st;  e.tag = tag;
        sb_q.push_back(e);
        @(negedge clock);
        check_out();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.pc_cur = '0;  bus.stall_req = 1'b0;  bus.branch_taken = 1'b0;
        bus.branch_target = '0;  bus.jump = 1'b0;  bus.jump_target = '0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;

        // reset, free run
        tbl.push_back(mk(0, 32'h1234, 0,0,0, 0,0, 32'h0, 1,1,1,0,0, HOLD));
        tbl.push_back(mk(1, 32'h0,    0,0,0, 0,0, 32'h0, 1,1,1,0,0, HOLD));
        tbl.push_back(mk(1, 32'h0,    0,0,0, 0,0, 32'h4, 1,1,0,0,0, RUN));
        tbl.push_back(mk(1, 32'h4,    0,0,0, 0,0, 32'h8, 1,1,0,0,0, RUN));
        tbl.push_back(mk(1, 32'h8,    0,0,0, 0,0, 32'hC, 1,1,0,0,0, RUN));
        // branch then squashed branch in FLUSH
        tbl.push_back(mk(1, 32'h40,  0,1,32'h100, 0,0, 32'h100, 1,1,1,0,0, RUN));
        tbl.push_back(mk(1, 32'h100, 0,1,32'h200, 0,0, 32'h104, 1,1,0,0,0, FLUSH));
        // stall beats jump, jump taken afterwards
        tbl.push_back(mk(1, 32'h20,  1,0,0, 1,32'h300, 32'h20,  0,0,0,0,0, RUN));
        tbl.push_back(mk(1, 32'h20,  0,0,0, 1,32'h300, 32'h300, 1,1,1,0,0, STALL));
        tbl.push_back(mk(1, 32'h300, 1,0,0, 0,0,       32'h300, 0,0,0,0,0, FLUSH));
        tbl.push_back(mk(1, 32'h300, 0,0,0, 0,0,       32'h304, 1,1,0,0,0, STALL));
        // wrap and misaligned jump
        tbl.push_back(mk(1, 32'hFFFF_FFFC, 0,0,0, 0,0, 32'h0, 1,1,0,0,0, RUN));
        tbl.push_back(mk(1, 32'h0,  0,0,0, 1,32'h102, MIS1, 1,1,1,0,EXC_EN, RUN));
        tbl.push_back(mk(1, MIS1,   0,0,0, 0,0, MIS1 + 32'd4, 1,1,0,0,0, FLUSH));
        // jump beats branch
        tbl.push_back(mk(1, 32'h10, 0,1,32'h600, 1,32'h500, 32'h500, 1,1,1,0,0, RUN));
        tbl.push_back(mk(1, 32'h500, 0,0,0, 0,0, 32'h504, 1,1,0,0,0, FLUSH));
        // misaligned branch
        tbl.push_back(mk(1, 32'h50, 0,1,32'h703, 0,0, MIS2, 1,1,1,0,EXC_EN, RUN));
        tbl.push_back(mk(1, MIS2,   0,0,0, 0,0, MIS2 + 32'd4, 1,1,0,0,0, FLUSH));
        // reset during STALL
        tbl.push_back(mk(1, 32'h704, 1,0,0, 0,0, 32'h704, 0,0,0,0,0, RUN));
        tbl.push_back(mk(1, 32'h704, 1,0,0, 0,0, 32'h704, 0,0,0,0,0, STALL));
        tbl.push_back(mk(0, 32'h704, 1,0,0, 0,0, 32'h0,   1,1,1,0,0, STALL));
        tbl.push_back(mk(1, 32'h0,   0,0,0, 0,0, 32'h0,   1,1,1,0,0, HOLD));
        tbl.push_back(mk(1, 32'h0,   0,0,0, 0,0, 32'h4,   1,1,0,0,0, RUN));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // short stall then release: counter must clear
        step(mk(1, 32'h800, 1,0,0, 0,0, 32'h800, 0,0,0,0,0, RUN), 100);
        for (int k = 1; k <= 3; k++) begin
            step(mk(1, 32'h800, 1,0,0, 0,0, 32'h800, 0,0,0,0,0, STALL), 100 + k);
        end
        step(mk(1, 32'h800, 0,0,0, 0,0, 32'h804, 1,1,0,0,0, STALL), 104);

        // long stall: flag rises on the 15th STALL cycle
        step(mk(1, 32'h804, 1,0,0, 0,0, 32'h804, 0,0,0,0,0, RUN), 200);
        for (int k = 1; k <= 15; k++) begin
            step(mk(1, 32'h804, 1,0,0, 0,0, 32'h804, 0,0,0,
                    logic'(k == 15), 0, STALL), 200 + k);
        end
        step(mk(1, 32'h804, 0,0,0, 0,0, 32'h808, 1,1,0,1,0, STALL), 216);
        step(mk(1, 32'h808, 0,0,0, 0,0, 32'h80C, 1,1,0,1,0, RUN),   217);
        step(mk(0, 32'h80C, 0,0,0, 0,0, 32'h0,   1,1,1,1,0, RUN),   218);
        step(mk(1, 32'h0,   0,0,0, 0,0, 32'h0,   1,1,1,0,0, HOLD),  219);
        step(mk(1, 32'h0,   0,0,0, 0,0, 32'h4,   1,1,0,0,0, RUN),   220);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expectations left", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_controller.md
PC_CONTROLLER -- requirements
Module: pc_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter STALL_MAX, default 15: stall length (cycles) that sets stall_timeout; range 1..15.
REQ-003 clock  in  1  rising-edge clock, sole clock domain.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 pc_cur  in  32  current PC register output.
REQ-006 stall_req  in  1  load-use hazard request from hazard unit.
REQ-007 branch_taken  in  1  taken branch resolved in ID.
REQ-008 branch_target  in  32  branch destination.
REQ-009 jump  in  1  jump decoded in ID.
REQ-010 jump_target  in  32  jump destination.
REQ-011 pc_next  out  32  value for PC register input, loaded every clock.
REQ-012 pc_write  out  1  high when pc_next differs from a hold of pc_cur.
REQ-013 if_id_write  out  1  IF/ID register enable.
REQ-014 if_id_flush  out  1  squash IF/ID contents.
REQ-015 stall_timeout  out  1  sticky stall-overrun flag.
REQ-016 state  out  2  current FSM state, for debug.

Function
REQ-017 FSM states SHALL be HOLD (reset-hold), RUN, STALL and FLUSH; all outputs are combinational from state and inputs.
REQ-018 Priority SHALL be reset > stall_req > jump > branch_taken > sequential.
REQ-019 HOLD: pc_next=RESET_PC, pc_write=1, if_id_flush=1, if_id_write=1; next state RUN.
REQ-020 RUN/STALL, no event: pc_next=pc_cur+4 modulo 2^32 (32'hFFFF_FFFC -> 0), if_id_write=1; next state RUN.
REQ-021 stall_req=1 in RUN/STALL: pc_next=pc_cur, pc_write=0, if_id_write=0, redirects ignored; next state STALL.
REQ-022 STALL with stall_req=0: advances per REQ-020/REQ-023 in the same cycle; the stall counter clears.
REQ-023 jump or branch_taken (stall_req=0) in RUN/STALL: pc_next=selected target, pc_write=1, if_id_flush=1; next state FLUSH.
REQ-024 FLUSH lasts exactly one cycle: redirect inputs SHALL be ignored (squashed slot), stall_req honoured per REQ-021, otherwise pc_next=pc_cur+4; next state RUN.
REQ-025 A 4-bit stall counter SHALL increment each STALL cycle, saturating at 15; reaching STALL_MAX SHALL set stall_timeout, which holds until reset; stalling continues while stall_req=1.
REQ-026 Target with bits[1:0]!=0 SHALL be handled per REQ-030/REQ-031.

Reset
REQ-027 reset_n=0 at a rising edge SHALL set state=HOLD, clear the stall counter and clear stall_timeout.
REQ-028 While reset_n=0, pc_next SHALL be RESET_PC, pc_write=1 and if_id_flush=1 regardless of state; reset mid-stall or mid-flush abandons the operation.
REQ-029 The first edge with reset_n=1 SHALL leave HOLD for RUN; the PC equals RESET_PC after that edge.

Configuration
REQ-030 With PC_EXC_EN defined: misaligned target SHALL give pc_next=EXC_VECTOR (32'h8000_0180), if_id_flush=1, output exc_taken=1 for that cycle, next state FLUSH.
REQ-031 Without PC_EXC_EN: port exc_taken SHALL be absent; target bits[1:0] forced to 2'b00 and used as a normal redirect.

Structure
REQ-032 Package pc_ctrl_pkg SHALL hold the state enum, EXC_VECTOR, INSTR_BYTES=4 and the default RESET_PC.
REQ-033 The stall counter and timeout flag SHALL be a sub-module pc_stall_watchdog (inputs: clock, reset_n, count_en, clear; output: timeout).

Verification
REQ-034 Reset, then 3 free-running cycles -> pc_next sequence 0, 4, 8, 12; state HOLD then RUN.
REQ-035 pc_cur=32'h40, branch_taken=1, target 32'h100 -> pc_next=32'h100, if_id_flush=1; next cycle FLUSH ignores branch_taken=1, target 32'h200.
REQ-036 stall_req=1 and jump=1 together at pc_cur=32'h20 -> pc_next=32'h20, if_id_write=0; jump re-presented after the stall is taken.
REQ-037 stall_req held 15 cycles with STALL_MAX=15 -> stall_timeout rises on the 15th STALL cycle and stays high until reset_n=0.
REQ-038 pc_cur=32'hFFFF_FFFC, no event -> pc_next=0; jump_target=32'h102 -> 32'h8000_0180 with PC_EXC_EN, 32'h100 without.
REQ-039 reset_n=0 during the STALL state -> pc_next=RESET_PC immediately; HOLD at next edge, counter cleared.
